noise_channel_core: RTL

- Waveform and gating stage of audio channel 4 (noise), directly downstream of the channel-4 volume envelope.
- Generates the pseudo-random bit stream with a 15/7-bit LFSR clocked by an NR43-programmed frequency timer.
- Applies the length counter, trigger and DAC-enable rules, then scales the LFSR bit by the envelope's volume_level.
- Feeds a 4-bit unsigned sample to the channel mixer.

---
 rtl/noise_channel_core_if.sv | 27 ++
 rtl/noise_channel_core.sv | 95 +++++++++
 2 files changed

// File: rtl/noise_channel_core_if.sv
// Register/strobe bundle between the APU register file and the channel-4 noise core.
// The master drives the NR4x fields and frame-sequencer strobes; the slave is the core.
interface noise_channel_core_if;
  logic [7:0]  NR43;
  logic        trigger;
  logic        length_enable;
  logic        length_load;
  logic [5:0]  length_data;
  logic        length_tick;
  logic        dac_enable;
  logic [3:0]  volume_level;
  logic [3:0]  sample;
  logic        channel_on;
  logic [14:0] lfsr_state;

  modport master (
    output NR43, trigger, length_enable, length_load, length_data,
           length_tick, dac_enable, volume_level,
    input  sample, channel_on, lfsr_state
  );

  modport slave (
    input  NR43, trigger, length_enable, length_load, length_data,
           length_tick, dac_enable, volume_level,
    output sample, channel_on, lfsr_state
  );
endinterface

// File: rtl/noise_channel_core.sv
// Channel-4 noise stage: NR43-timed 15/7-bit LFSR, length counter, trigger/DAC gating,
// and envelope-volume scaling of the LFSR output bit.
module noise_channel_core #(
  parameter int TIMER_W = 20,
  parameter int LEN_W   = 7
) (
  input  logic                clock_64,
  input  logic                reset,
  noise_channel_core_if.slave bus
);

  logic [14:0]        lfsr_q, lfsr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               on_q, on_d;

  logic [3:0]         shiftS;
  logic               widthMode;
  logic [2:0]         divCode;
  logic [TIMER_W-1:0] divisor;
  logic [TIMER_W-1:0] periodM1;
  logic               timerRun;
  logic               feedback;
  logic [14:0]        lfsrStep;
  logic               lenDec;

  assign shiftS    = bus.NR43[7:4];
  assign widthMode = bus.NR43[3];
  assign divCode   = bus.NR43[2:0];

  // Shifts of 14 and 15 freeze the timer entirely; the period is only sampled at reload.
  assign timerRun  = (shiftS < 4'd14);
  assign divisor   = (divCode == 3'd0) ? TIMER_W'(8) : TIMER_W'({divCode, 4'b0000});
  assign periodM1  = (divisor << shiftS) - TIMER_W'(1);

  assign feedback  = lfsr_q[0] ^ lfsr_q[1];
  always_comb begin
    lfsrStep = {feedback, lfsr_q[14:1]};
    if (widthMode) lfsrStep[6] = feedback;
  end

  // A load in the same cycle wins over a tick, so the tick is dropped rather than applied.
  assign lenDec = bus.length_tick && bus.length_enable && (len_q != '0) &&
                  !bus.trigger && !bus.length_load;

  always_comb begin
    lfsr_d  = lfsr_q;
    timer_d = timer_q;
    len_d   = len_q;
    on_d    = on_q;

    if (bus.trigger) begin
      lfsr_d  = 15'h7FFF;
      timer_d = periodM1;
      on_d    = bus.dac_enable;
      if (len_q == '0) len_d = LEN_W'(64);
    end else begin
      if (timerRun) begin
        if (timer_q == '0) begin
          timer_d = periodM1;
          lfsr_d  = lfsrStep;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      if (lenDec) begin
        len_d = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) on_d = 1'b0;
      end
    end

    if (bus.length_load) len_d = LEN_W'(64) - LEN_W'(bus.length_data);
    if (!bus.dac_enable) on_d = 1'b0;
  end

  always_ff @(posedge clock_64 or posedge reset) begin
    if (reset) begin
      lfsr_q  <= 15'h7FFF;
      timer_q <= '0;
      len_q   <= '0;
      on_q    <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      on_q    <= on_d;
    end
  end

  // The channel outputs volume while LFSR bit 0 is low; volume is deliberately unregistered.
  assign bus.sample     = (on_q && bus.dac_enable && !lfsr_q[0]) ? bus.volume_level : 4'd0;
  assign bus.channel_on = on_q;
  assign bus.lfsr_state = lfsr_q;

endmodule
